sobel_window_feeder: RTL and testbench



---
 rtl/sobel_window_feeder_if.sv | 32 +++
 rtl/sobel_window_feeder.sv | 168 ++++++++++++++++
 tb/tb_sobel_window_feeder.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_window_feeder_if.sv
// Pixel-in, gradient-engine and result-out signals of the Sobel window feeder.
// master: feeder side (drives o_*/P*); slave: environment side (drives i_*).
interface sobel_window_feeder_if;
    logic       i_pixel_valid;
    logic [7:0] i_pixel;
    logic       o_pixel_ready;
    logic [7:0] P0, P1, P2, P3, P4, P5, P6, P7, P8;
    logic       o_gradient_start;
    logic       i_gradient_data_ready;
    logic [7:0] i_processed_sum;
    logic       o_result_valid;
    logic [7:0] o_result;
    logic       i_result_ready;
    logic       o_frame_done;
    logic       o_timeout;

    modport master (
        input  i_pixel_valid, i_pixel, i_gradient_data_ready,
        input  i_processed_sum, i_result_ready,
        output o_pixel_ready, o_gradient_start, o_result_valid,
        output o_result, o_frame_done, o_timeout,
        output P0, P1, P2, P3, P4, P5, P6, P7, P8
    );

    modport slave (
        output i_pixel_valid, i_pixel, i_gradient_data_ready,
        output i_processed_sum, i_result_ready,
        input  o_pixel_ready, o_gradient_start, o_result_valid,
        input  o_result, o_frame_done, o_timeout,
        input  P0, P1, P2, P3, P4, P5, P6, P7, P8
    );
endinterface

// File: rtl/sobel_window_feeder.sv
// Buffers two rows of a raster pixel stream, issues each interior 3x3 window
// to edge_detection and forwards the returned sum on a valid/ready port.
// Ports: clk, rst (sync, active high), bus (sobel_window_feeder_if.master).
// Optional macro SOBEL_FEEDER_TIMEOUT_EN adds a WAIT watchdog and o_timeout.
module sobel_window_feeder #(
    parameter int IMG_WIDTH      = 16,
    parameter int IMG_HEIGHT     = 16,
    parameter int TIMEOUT_CYCLES = 32
) (
    input logic                   clk,
    input logic                   rst,
    sobel_window_feeder_if.master bus
);
    localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    typedef enum logic [1:0] {S_FILL, S_ISSUE, S_WAIT, S_OUTPUT} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [7:0]    win_q [9];
    logic [7:0]    win_d [9];
    logic [7:0]    result_q, result_d;
    logic          last_q, last_d;
    logic          frame_done_q, frame_done_d;
    logic [7:0]    lb0_q [IMG_WIDTH];
    logic [7:0]    lb1_q [IMG_WIDTH];
    logic [7:0]    lb0_rd, lb1_rd;
    logic          accept, win_ok, frame_end;

`ifdef SOBEL_FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          timeout_q, timeout_d;
`endif

    assign accept    = bus.i_pixel_valid && (state_q == S_FILL);
    assign win_ok    = (row_q >= ROW_TWO) && (col_q >= COL_TWO);
    assign frame_end = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign lb0_rd    = lb0_q[col_q];
    assign lb1_rd    = lb1_q[col_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FILL;
            col_q        <= '0;
            row_q        <= '0;
            result_q     <= '0;
            last_q       <= 1'b0;
            frame_done_q <= 1'b0;
            for (int k = 0; k < 9; k++) win_q[k] <= '0;
`ifdef SOBEL_FEEDER_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            result_q     <= result_d;
            last_q       <= last_d;
            frame_done_q <= frame_done_d;
            win_q        <= win_d;
`ifdef SOBEL_FEEDER_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    // Line buffers hold the previous two rows; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            lb1_q[col_q] <= lb0_rd;
            lb0_q[col_q] <= bus.i_pixel;
        end
    end

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        result_d     = result_q;
        last_d       = last_q;
        frame_done_d = 1'b0;
`ifdef SOBEL_FEEDER_TIMEOUT_EN
        tmo_cnt_d    = '0;
        timeout_d    = timeout_q;
`endif
        unique case (state_q)
            S_FILL: begin
                if (accept) begin
                    for (int r = 0; r < 3; r++) begin
                        win_d[3*r]   = win_q[3*r+1];
                        win_d[3*r+1] = win_q[3*r+2];
                    end
                    win_d[2] = lb1_rd;
                    win_d[5] = lb0_rd;
                    win_d[8] = bus.i_pixel;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    if (win_ok) begin
                        state_d = S_ISSUE;
                        last_d  = frame_end;
                    end
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
`ifdef SOBEL_FEEDER_TIMEOUT_EN
                tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
                if (bus.i_gradient_data_ready) begin
                    result_d = bus.i_processed_sum;
                    state_d  = S_OUTPUT;
                end
`ifdef SOBEL_FEEDER_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    result_d  = '0;
                    timeout_d = 1'b1;
                    state_d   = S_OUTPUT;
                end
`endif
            end
            S_OUTPUT: begin
                if (bus.i_result_ready) begin
                    state_d      = S_FILL;
                    frame_done_d = last_q;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_comb begin
        bus.o_pixel_ready    = (state_q == S_FILL);
        bus.o_gradient_start = (state_q == S_ISSUE);
        bus.o_result_valid   = (state_q == S_OUTPUT);
    end

    assign bus.P0           = win_q[0];
    assign bus.P1           = win_q[1];
    assign bus.P2           = win_q[2];
    assign bus.P3           = win_q[3];
    assign bus.P4           = win_q[4];
    assign bus.P5           = win_q[5];
    assign bus.P6           = win_q[6];
    assign bus.P7           = win_q[7];
    assign bus.P8           = win_q[8];
    assign bus.o_result     = result_q;
    assign bus.o_frame_done = frame_done_q;
`ifdef SOBEL_FEEDER_TIMEOUT_EN
    assign bus.o_timeout    = timeout_q;
`else
    assign bus.o_timeout    = 1'b0;
`endif
endmodule

// File: tb/tb_sobel_window_feeder.sv
// Self-checking bench for sobel_window_feeder on a 4x3 image.
// Reference model works from pixel indices and the image array.
module tb_sobel_window_feeder;
    localparam int W    = 4;
    localparam int H    = 3;
    localparam int N    = W * H;
    localparam int NWIN = (W - 2) * (H - 2);
    localparam int TMO  = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sobel_window_feeder_if bus ();

    sobel_window_feeder #(
        .IMG_WIDTH      (W),
        .IMG_HEIGHT     (H),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] img [N];

    function automatic logic [71:0] exp_win(input int r, input int c);
        logic [71:0] v;
        v = '0;
        for (int k = 0; k < 9; k++)
            v[71-8*k -: 8] = img[(r - 2 + k / 3) * W + (c - 2 + k % 3)];
        return v;
    endfunction

    function automatic logic [71:0] act_win();
        return {bus.P0, bus.P1, bus.P2, bus.P3, bus.P4,
                bus.P5, bus.P6, bus.P7, bus.P8};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_pixel_valid         = 1'b0;
        bus.i_pixel               = '0;
        bus.i_gradient_data_ready = 1'b0;
        bus.i_processed_sum       = '0;
        bus.i_result_ready        = 1'b0;
    endtask

    task automatic ramp_image();
        for (int i = 0; i < N; i++) img[i] = 8'(i);
    endtask

    // Feeds pixels until a start pulse is seen; ok=0 if the bound expires.
    task automatic stream_until_start(output bit ok);
        int idx;
        idx = 0;
        ok  = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (bus.o_gradient_start) begin
                ok = 1'b1;
                break;
            end
            bus.i_pixel_valid = bus.o_pixel_ready && (idx < N);
            bus.i_pixel       = (idx < N) ? img[idx] : 8'h00;
            if (bus.i_pixel_valid) idx++;
            tick();
        end
        bus.i_pixel_valid = 1'b0;
    endtask

    // vmode: 0 always valid, 1 toggling, 2 random
    // rmode: 0 ready=1, 1 ready low first 5 OUTPUT cycles, 2 random
    // dly 0 picks a random responder delay per window
    task automatic run_frame(input string name, input int vmode,
                             input int rmode, input int dly,
                             input bit noise, input bit fixed);
        int idx, done, cyc, rcnt, ocyc, wr, wc;
        bit busy, idue, vexp, fdue, tog, v, rr, b0, st, fire;
        logic [7:0] sum;
        idx = 0; done = 0; cyc = 0; rcnt = 0; ocyc = 0; wr = 0; wc = 0;
        busy = 0; idue = 0; vexp = 0; fdue = 0; tog = 0;
        sum = 8'd37;
        while (done < NWIN && cyc < 4000) begin
            cyc++;
            n_checks++;
            if (bus.o_pixel_ready !== !busy) begin
                n_fail++;
                $display("FAIL %s pixel_ready cyc %0d: got %b want %b",
                         name, cyc, bus.o_pixel_ready, !busy);
            end
            n_checks++;
            if (bus.o_gradient_start !== idue) begin
                n_fail++;
                $display("FAIL %s start cyc %0d: got %b want %b",
                         name, cyc, bus.o_gradient_start, idue);
            end
            n_checks++;
            if (bus.o_result_valid !== vexp) begin
                n_fail++;
                $display("FAIL %s result_valid cyc %0d: got %b want %b",
                         name, cyc, bus.o_result_valid, vexp);
            end
            n_checks++;
            if (bus.o_frame_done !== fdue) begin
                n_fail++;
                $display("FAIL %s frame_done cyc %0d: got %b want %b",
                         name, cyc, bus.o_frame_done, fdue);
            end
            n_checks++;
            if (bus.o_timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL %s timeout cyc %0d: got %b want 0",
                         name, cyc, bus.o_timeout);
            end
            if (busy) begin
                n_checks++;
                if (act_win() !== exp_win(wr, wc)) begin
                    n_fail++;
                    $display("FAIL %s window cyc %0d: got %h want %h",
                             name, cyc, act_win(), exp_win(wr, wc));
                end
            end
            if (vexp) begin
                n_checks++;
                if (bus.o_result !== sum) begin
                    n_fail++;
                    $display("FAIL %s result cyc %0d: got %0d want %0d",
                             name, cyc, bus.o_result, sum);
                end
            end
            b0 = busy; st = idue; fire = 0;
            idue = 0; fdue = 0;
            bus.i_gradient_data_ready = 1'b0;
            bus.i_processed_sum       = 8'($urandom);
            if (st) begin
                rcnt = (dly > 0) ? dly : int'($urandom_range(1, 20));
                sum  = fixed ? 8'd37 : 8'($urandom);
                if (noise) begin
                    bus.i_gradient_data_ready = 1'b1;
                    bus.i_processed_sum       = ~sum;
                end
            end else if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) begin
                    bus.i_gradient_data_ready = 1'b1;
                    bus.i_processed_sum       = sum;
                    fire = 1;
                end
            end
            case (rmode)
                0:       rr = 1'b1;
                1:       rr = (ocyc >= 5);
                default: rr = 1'($urandom);
            endcase
            bus.i_result_ready = rr;
            if (vexp) begin
                if (rr) begin
                    done++;
                    busy = 0; vexp = 0; ocyc = 0;
                    fdue = (wr == H - 1) && (wc == W - 1);
                end else begin
                    ocyc++;
                end
            end
            if (fire) vexp = 1;
            tog = ~tog;
            case (vmode)
                0:       v = (idx < N);
                1:       v = (idx < N) && tog;
                default: v = (idx < N) && 1'($urandom);
            endcase
            bus.i_pixel_valid = v;
            bus.i_pixel       = v ? img[idx] : 8'($urandom);
            if (v && !b0) begin
                if (idx / W >= 2 && idx % W >= 2) begin
                    busy = 1; idue = 1;
                    wr = idx / W; wc = idx % W;
                end
                idx++;
            end
            tick();
        end
        n_checks++;
        if (done != NWIN) begin
            n_fail++;
            $display("FAIL %s frame_budget: got %0d results want %0d",
                     name, done, NWIN);
        end
        idle_inputs();
        n_checks++;
        if (bus.o_frame_done !== fdue) begin
            n_fail++;
            $display("FAIL %s frame_done_pulse: got %b want %b",
                     name, bus.o_frame_done, fdue);
        end
        tick();
        n_checks++;
        if (bus.o_frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s frame_done_end: got %b want 0",
                     name, bus.o_frame_done);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if (act_win() !== 72'h0 || bus.o_gradient_start !== 1'b0 ||
            bus.o_result_valid !== 1'b0 || bus.o_result !== 8'h00 ||
            bus.o_frame_done !== 1'b0 || bus.o_timeout !== 1'b0 ||
            bus.o_pixel_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: got P=%h st=%b v=%b r=%h fd=%b to=%b rdy=%b want zeros rdy=1",
                     name, act_win(), bus.o_gradient_start,
                     bus.o_result_valid, bus.o_result, bus.o_frame_done,
                     bus.o_timeout, bus.o_pixel_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.i_pixel_valid         = 1'($urandom);
            bus.i_pixel               = 8'($urandom);
            bus.i_gradient_data_ready = 1'($urandom);
            bus.i_processed_sum       = 8'($urandom);
            bus.i_result_ready        = 1'($urandom);
            tick();
        end
        check_reset_outputs("reset");
        idle_inputs();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_first_frame();
        ramp_image();
        run_frame("first_frame", 0, 0, 18, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        ramp_image();
        run_frame("backpressure", 0, 1, 18, 1'b0, 1'b1);
    endtask

    task automatic test_bubbles();
        ramp_image();
        run_frame("bubbles", 1, 0, 18, 1'b1, 1'b1);
    endtask

    task automatic test_mid_reset();
        bit ok;
        ramp_image();
        stream_until_start(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL mid_reset start_seen: got 0 want 1");
        end
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_reset_outputs("mid_reset");
        rst = 1'b0;
        run_frame("after_reset", 0, 0, 18, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < N; i++) img[i] = 8'($urandom);
            run_frame("random", 2, 2, 0, 1'($urandom), 1'b0);
        end
    endtask

`ifdef SOBEL_FEEDER_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        ramp_image();
        stream_until_start(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL timeout start_seen: got 0 want 1");
        end
        tick();
        for (int k = 1; k < TMO; k++) tick();
        n_checks++;
        if (bus.o_result_valid !== 1'b0 || bus.o_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout early: got v=%b to=%b want 0 0",
                     bus.o_result_valid, bus.o_timeout);
        end
        tick();
        n_checks++;
        if (bus.o_result_valid !== 1'b1 || bus.o_result !== 8'h00 ||
            bus.o_timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout fire: got v=%b r=%0d to=%b want 1 0 1",
                     bus.o_result_valid, bus.o_result, bus.o_timeout);
        end
        bus.i_result_ready = 1'b1;
        tick();
        bus.i_result_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (bus.o_timeout !== 1'b1 || bus.o_result_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout sticky: got to=%b v=%b want 1 0",
                         bus.o_timeout, bus.o_result_valid);
            end
            tick();
        end
        rst = 1'b1;
        tick();
        check_reset_outputs("timeout_clear");
        rst = 1'b0;
        tick();
    endtask
`endif

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_first_frame();
        test_backpressure();
        test_bubbles();
        test_mid_reset();
        test_random();
`ifdef SOBEL_FEEDER_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
